// File: rtl/f5_sweep_ctrl.sv
// Exhaustive 3-input sweep controller: drives every {x,y,z} vector to two
// implementations of the same function, compares them with each other and with a golden table.
module f5_sweep_ctrl #(
  parameter logic [7:0] EXPECT = 8'hA2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop_on_err,
  input  logic       sa,
  input  logic       sb,
  output logic       x,
  output logic       y,
  output logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_bad,
  output logic       bad_valid,
  output logic [7:0] truth
);

  // state  | meaning
  // IDLE   | waiting for start, results held
  // DRIVE  | vector applied, implementations settling
  // SAMPLE | sa/sb compared and recorded at the exiting edge
  // DONE   | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] ERR_MAX = 4'd8;

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [2:0] vec_q, vec_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [2:0] first_bad_q, first_bad_d;
  logic       bad_valid_q, bad_valid_d;
  logic [7:0] truth_q, truth_d;

  logic mismatch;
  logic last_vec;
  logic end_sweep;

  assign mismatch  = (sa != sb) | (sa != EXPECT[idx_q]);
  assign last_vec  = (idx_q == 3'd7);
  assign end_sweep = (mismatch & stop_on_err) | last_vec;

  // State register; reset outranks every transition, so an aborted sweep never pulses done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      vec_q       <= 3'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= 4'd0;
      first_bad_q <= 3'd0;
      bad_valid_q <= 1'b0;
      truth_q     <= 8'h00;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      first_bad_q <= first_bad_d;
      bad_valid_q <= bad_valid_d;
      truth_q     <= truth_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = DRIVE;
      DRIVE:   state_d = SAMPLE;
      SAMPLE:  state_d = end_sweep ? DONE : DRIVE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; everything holds unless updated below.
  always_comb begin
    idx_d       = idx_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    first_bad_d = first_bad_q;
    bad_valid_d = bad_valid_q;
    truth_d     = truth_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d       = 3'd0;
          vec_d       = 3'd0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_d       = 4'd0;
          first_bad_d = 3'd0;
          bad_valid_d = 1'b0;
          truth_d     = 8'h00;
        end
      end
      SAMPLE: begin
        truth_d[idx_q] = sa;
        if (mismatch) begin
          if (err_q != ERR_MAX) err_d = err_q + 4'd1;
          if (!bad_valid_q) begin
            first_bad_d = idx_q;
            bad_valid_d = 1'b1;
          end
        end
        if (end_sweep) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          // Pass only when the final vector is reached and nothing ever mismatched.
          pass_d = last_vec & ~mismatch & (err_q == 4'd0);
        end else begin
          idx_d = idx_q + 3'd1;
          vec_d = idx_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  assign {x, y, z}  = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_bad  = first_bad_q;
  assign bad_valid  = bad_valid_q;
  assign truth      = truth_q;

endmodule

// File: tb/tb_f5_sweep_ctrl.sv
// Directed bench for f5_sweep_ctrl: models the two implementations from x/y/z
// and checks sweep timing and captured results against hand-computed values.
module tb_f5_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, stop_on_err, sa, sb;
  logic       x, y, z, busy, done, pass, bad_valid;
  logic [3:0] err_count;
  logic [2:0] first_bad;
  logic [7:0] truth;

  int checks = 0;
  int errors = 0;
  int mode   = 0;  // 0 correct, 1 sb stuck at 0, 2 both inverted

  f5_sweep_ctrl #(.EXPECT(8'hA2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop_on_err(stop_on_err),
    .sa(sa), .sb(sb), .x(x), .y(y), .z(z), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count), .first_bad(first_bad),
    .bad_valid(bad_valid), .truth(truth)
  );

  always #5 clk = ~clk;

  logic f_a, f_b;
  always_comb begin
    f_a = (~x & ~y & z) | (x & ~y & z) | (x & y & z);
    f_b = (x & z) | (~y & z);
    sa  = f_a;
    sb  = f_b;
    case (mode)
      1: sb = 1'b0;
      2: begin sa = ~f_a; sb = ~f_b; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then watches 30 cycles after the accept edge (cycle 1 = first after it).
  task automatic sweep(input bit repulse, output int dcyc, output int dcnt,
                       output logic busy_at_done, output logic [2:0] vec_at_done);
    dcyc = 0; dcnt = 0; busy_at_done = 1'bx; vec_at_done = 3'bxxx;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_cycle1", busy, 1);
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (done === 1'b1) begin
        dcnt++;
        if (dcyc == 0) begin
          dcyc = c; busy_at_done = busy; vec_at_done = {x, y, z};
        end
      end
      start = (repulse && (c == 6 || c == 16)) ? 1'b1 : 1'b0;
    end
  endtask

  task automatic chk_results(input string tag, input logic p, input logic [3:0] ec,
                             input logic [2:0] fb, input logic bv, input logic [7:0] tr);
    chk({tag, "_pass"}, pass, p);
    chk({tag, "_err_count"}, err_count, ec);
    chk({tag, "_first_bad"}, first_bad, fb);
    chk({tag, "_bad_valid"}, bad_valid, bv);
    chk({tag, "_truth"}, truth, tr);
    chk({tag, "_busy_idle"}, busy, 0);
  endtask

  int dcyc, dcnt;
  logic bd;
  logic [2:0] vd;

  initial begin
    reset = 1'b1; start = 1'b0; stop_on_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_xyz", {x, y, z}, 0);
    chk_results("rst", 0, 0, 0, 0, 8'h00);
    @(negedge clk); reset = 1'b0;

    // Correct models, full sweep
    mode = 0; stop_on_err = 1'b0;
    sweep(0, dcyc, dcnt, bd, vd);
    chk("s1_done_cycle", dcyc, 17);
    chk("s1_done_count", dcnt, 1);
    chk("s1_busy_at_done", bd, 0);
    chk("s1_xyz_last", {x, y, z}, 3'b111);
    chk_results("s1", 1, 0, 0, 0, 8'hA2);

    // sb stuck at 0, run through
    mode = 1; stop_on_err = 1'b0;
    sweep(0, dcyc, dcnt, bd, vd);
    chk("s2_done_cycle", dcyc, 17);
    chk("s2_done_count", dcnt, 1);
    chk_results("s2", 0, 3, 1, 1, 8'hA2);

    // sb stuck at 0, stop at first error
    mode = 1; stop_on_err = 1'b1;
    sweep(0, dcyc, dcnt, bd, vd);
    chk("s3_done_cycle", dcyc, 5);
    chk("s3_done_count", dcnt, 1);
    chk("s3_xyz_at_done", vd, 3'b001);
    chk("s3_xyz_hold", {x, y, z}, 3'b001);
    chk_results("s3", 0, 1, 1, 1, 8'h02);

    // Both implementations inverted: every vector mismatches the golden table
    mode = 2; stop_on_err = 1'b0;
    sweep(0, dcyc, dcnt, bd, vd);
    chk("s4_done_cycle", dcyc, 17);
    chk_results("s4", 0, 8, 0, 1, 8'h5D);

    // start re-pulsed mid-sweep and during the final SAMPLE
    mode = 0; stop_on_err = 1'b0;
    sweep(1, dcyc, dcnt, bd, vd);
    chk("s5_done_cycle", dcyc, 17);
    chk("s5_done_count", dcnt, 1);
    chk_results("s5", 1, 0, 0, 0, 8'hA2);

    // Reset in cycle 8 of a failing sweep
    mode = 1; stop_on_err = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 2; c <= 8; c++) begin @(posedge clk); #1; end
    chk("s6_truth_before_reset", truth, 8'h02);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("s6_done", done, 0);
    chk("s6_xyz", {x, y, z}, 0);
    chk_results("s6", 0, 0, 0, 0, 8'h00);
    dcnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    chk("s6_no_done_after_abort", dcnt, 0);
    mode = 0;
    sweep(0, dcyc, dcnt, bd, vd);
    chk("s6b_done_cycle", dcyc, 17);
    chk("s6b_done_count", dcnt, 1);
    chk_results("s6b", 1, 0, 0, 0, 8'hA2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
